// File: rtl/xadc_drp_fake_source.sv
// ============================================================================
// Module   : xadc_drp_fake_source
// Purpose  : Synthetic XADC DRP-to-AXIS source producing ramped voltage and
//            current samples after each end-of-sequence event.
//            Optional macro XADC_FAKE_NOISE_EN adds LFSR dither to code[1:0].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xadc_drp_fake_source #(
    parameter int unsigned SAMPLE_PERIOD = 100,
    parameter logic [11:0] VOLTAGE_START = 12'h800,
    parameter logic [11:0] VOLTAGE_STEP  = 12'd1,
    parameter logic [11:0] CURRENT_START = 12'h100,
    parameter logic [11:0] CURRENT_STEP  = 12'd3
) (
    input  logic        xadc_dclk,
    input  logic        xadc_reset_n,
    output logic [15:0] voltage_tdata,
    output logic        voltage_tvalid,
    input  logic        voltage_tready,
    output logic [15:0] current_tdata,
    output logic        current_tvalid,
    input  logic        current_tready,
    output logic        eos,
    output logic [7:0]  overrun_count
);

    localparam logic [15:0] c_LAST = 16'(SAMPLE_PERIOD - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        cur_trig_q;
    logic [11:0] vramp_q, vramp_d;
    logic [11:0] cramp_q, cramp_d;
    logic [15:0] vdata_q, vdata_d;
    logic [15:0] cdata_q, cdata_d;
    logic        vvalid_q, vvalid_d;
    logic        cvalid_q, cvalid_d;
    logic [7:0]  ovf_q, ovf_d;
    logic        w_eos;
    logic        w_v_drop;
    logic        w_c_drop;
    logic [8:0]  w_ovf_sum;
    logic [1:0]  w_noise;

`ifdef XADC_FAKE_NOISE_EN
    logic [15:0] lfsr_q;
    logic        w_fb;

    assign w_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign w_noise = lfsr_q[1:0];

    always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
        if (!xadc_reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], w_fb};
        end
    end
`else
    assign w_noise = 2'b00;
`endif

    assign w_eos = (cnt_q == c_LAST);

    always_comb begin
        cnt_d    = w_eos ? 16'd0 : cnt_q + 16'd1;
        vramp_d  = vramp_q;
        cramp_d  = cramp_q;
        vdata_d  = vdata_q;
        cdata_d  = cdata_q;
        vvalid_d = vvalid_q;
        cvalid_d = cvalid_q;
        w_v_drop = 1'b0;
        w_c_drop = 1'b0;

        // A slot may only be refilled if empty or being emptied this cycle.
        if (w_eos) begin
            vramp_d = vramp_q + VOLTAGE_STEP;
            if (!vvalid_q || voltage_tready) begin
                vdata_d  = {vramp_q ^ {10'd0, w_noise}, 4'h0};
                vvalid_d = 1'b1;
            end else begin
                w_v_drop = 1'b1;
            end
        end else if (vvalid_q && voltage_tready) begin
            vvalid_d = 1'b0;
        end

        if (cur_trig_q) begin
            cramp_d = cramp_q + CURRENT_STEP;
            if (!cvalid_q || current_tready) begin
                cdata_d  = {cramp_q ^ {10'd0, w_noise}, 4'h0};
                cvalid_d = 1'b1;
            end else begin
                w_c_drop = 1'b1;
            end
        end else if (cvalid_q && current_tready) begin
            cvalid_d = 1'b0;
        end

        w_ovf_sum = {1'b0, ovf_q} + {8'd0, w_v_drop} + {8'd0, w_c_drop};
        ovf_d     = w_ovf_sum[8] ? 8'hFF : w_ovf_sum[7:0];
    end

    always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
        if (!xadc_reset_n) begin
            cnt_q      <= 16'd0;
            cur_trig_q <= 1'b0;
            vramp_q    <= VOLTAGE_START;
            cramp_q    <= CURRENT_START;
            vdata_q    <= 16'h0000;
            cdata_q    <= 16'h0000;
            vvalid_q   <= 1'b0;
            cvalid_q   <= 1'b0;
            ovf_q      <= 8'd0;
        end else begin
            cnt_q      <= cnt_d;
            cur_trig_q <= w_eos;
            vramp_q    <= vramp_d;
            cramp_q    <= cramp_d;
            vdata_q    <= vdata_d;
            cdata_q    <= cdata_d;
            vvalid_q   <= vvalid_d;
            cvalid_q   <= cvalid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign voltage_tdata  = vdata_q;
    assign voltage_tvalid = vvalid_q;
    assign current_tdata  = cdata_q;
    assign current_tvalid = cvalid_q;
    assign eos            = w_eos;
    assign overrun_count  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_xadc_drp_fake_source.sv
// ============================================================================
// Module   : tb_xadc_drp_fake_source
// Purpose  : Randomized self-checking bench against a cycle-indexed model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xadc_drp_fake_source;

    localparam int P = 100;
`ifdef XADC_FAKE_NOISE_EN
    localparam logic [15:0] c_MASK = 16'hFFCF;
`else
    localparam logic [15:0] c_MASK = 16'hFFFF;
`endif

    logic        clk;
    logic        rst_n;
    logic        v_ready;
    logic        c_ready;
    logic [15:0] v_data, c_data;
    logic        v_valid, c_valid, eos;
    logic [7:0]  ovf;

    logic [15:0] wr_vdata, wr_cdata;
    logic        wr_vvalid, wr_cvalid, wr_eos;
    logic [7:0]  wr_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    xadc_drp_fake_source #(.SAMPLE_PERIOD(P)) u_dut (
        .xadc_dclk      (clk),
        .xadc_reset_n   (rst_n),
        .voltage_tdata  (v_data),
        .voltage_tvalid (v_valid),
        .voltage_tready (v_ready),
        .current_tdata  (c_data),
        .current_tvalid (c_valid),
        .current_tready (c_ready),
        .eos            (eos),
        .overrun_count  (ovf)
    );

    xadc_drp_fake_source #(.SAMPLE_PERIOD(8), .VOLTAGE_START(12'hFFF)) u_wrap (
        .xadc_dclk      (clk),
        .xadc_reset_n   (rst_n),
        .voltage_tdata  (wr_vdata),
        .voltage_tvalid (wr_vvalid),
        .voltage_tready (1'b1),
        .current_tdata  (wr_cdata),
        .current_tvalid (wr_cvalid),
        .current_tready (1'b1),
        .eos            (wr_eos),
        .overrun_count  (wr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: m_t is the cycle index since reset release.
    int          m_t;
    int          m_vr, m_cr, m_ovf;
    logic        m_vv, m_cv;
    logic [15:0] m_vd, m_cd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_vr = 12'h800; m_cr = 12'h100; m_ovf = 0;
            m_vv = 1'b0; m_cv = 1'b0; m_vd = 16'h0; m_cd = 16'h0;
        end else begin
            if (m_t % P == P - 1) begin
                if (!m_vv || v_ready) begin
                    m_vv = 1'b1; m_vd = 16'(m_vr * 16);
                end else begin
                    m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
                end
                m_vr = (m_vr + 1) % 4096;
            end else if (m_vv && v_ready) begin
                m_vv = 1'b0;
            end
            if (m_t >= P && m_t % P == 0) begin
                if (!m_cv || c_ready) begin
                    m_cv = 1'b1; m_cd = 16'(m_cr * 16);
                end else begin
                    m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
                end
                m_cr = (m_cr + 3) % 4096;
            end else if (m_cv && c_ready) begin
                m_cv = 1'b0;
            end
            m_t = m_t + 1;
        end
    end

    logic [42:0] w_obs, w_exp;
    logic        m_eos;
    assign m_eos = (m_t % P == P - 1);
    assign w_obs = {v_valid, v_data & c_MASK, c_valid, c_data & c_MASK, eos, ovf};
    assign w_exp = {m_vv, m_vd & c_MASK, m_cv, m_cd & c_MASK, m_eos, 8'(m_ovf)};

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; v_ready = 1'b1; c_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (w_obs !== 43'd0) begin
            n_fail++; $display("FAIL reset_main obs=%h exp=0", w_obs);
        end
        n_tests++;
        if ({wr_vvalid, wr_vdata, wr_cvalid, wr_cdata, wr_eos, wr_ovf} !== 43'd0) begin
            n_fail++; $display("FAIL reset_wrap obs=%h exp=0",
                {wr_vvalid, wr_vdata, wr_cvalid, wr_cdata, wr_eos, wr_ovf});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_period();
        do_reset(); v_ready = 1'b1; c_ready = 1'b1;
        repeat (205) begin
            @(negedge clk);
            n_tests++;
            if (w_obs !== w_exp) begin
                n_fail++; $display("FAIL first_model t=%0d obs=%h exp=%h", m_t, w_obs, w_exp);
            end
            if (m_t == 99) begin
                n_tests++;
                if (eos !== 1'b1) begin n_fail++; $display("FAIL first_eos obs=%b exp=1", eos); end
            end
            if (m_t == 100 || m_t == 200) begin
                n_tests++;
                if ({v_valid, v_data & c_MASK} !== {1'b1, (m_t == 100 ? 16'h8000 : 16'h8010) & c_MASK}) begin
                    n_fail++; $display("FAIL first_volt t=%0d obs=%b/%h", m_t, v_valid, v_data);
                end
            end
            if (m_t == 101 || m_t == 201) begin
                n_tests++;
                if ({c_valid, c_data & c_MASK} !== {1'b1, (m_t == 101 ? 16'h1000 : 16'h1030) & c_MASK}) begin
                    n_fail++; $display("FAIL first_curr t=%0d obs=%b/%h", m_t, c_valid, c_data);
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (20) begin
            @(negedge clk);
            if (m_t == 8 || m_t == 16) begin
                n_tests++;
                if ({wr_vvalid, wr_vdata & c_MASK} !== {1'b1, (m_t == 8 ? 16'hFFF0 : 16'h0000) & c_MASK}) begin
                    n_fail++; $display("FAIL wrap t=%0d obs=%b/%h", m_t, wr_vvalid, wr_vdata);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(); v_ready = 1'b0; c_ready = 1'b1;
        repeat (420) begin
            @(negedge clk);
            n_tests++;
            if (w_obs !== w_exp) begin
                n_fail++; $display("FAIL bp_model t=%0d obs=%h exp=%h", m_t, w_obs, w_exp);
            end
            if (m_t == 301) begin
                n_tests++;
                if ({c_valid, c_data & c_MASK} !== {1'b1, 16'h1060 & c_MASK}) begin
                    n_fail++; $display("FAIL bp_curr obs=%b/%h exp=1/1060", c_valid, c_data);
                end
            end
            if (m_t == 350) begin
                n_tests++;
                if ({ovf, v_valid, v_data & c_MASK} !== {8'd2, 1'b1, 16'h8000 & c_MASK}) begin
                    n_fail++; $display("FAIL bp_hold obs=%h/%b/%h exp=02/1/8000", ovf, v_valid, v_data);
                end
                v_ready = 1'b1;
            end
            if (m_t == 400) begin
                n_tests++;
                if ({v_valid, v_data & c_MASK} !== {1'b1, 16'h8030 & c_MASK}) begin
                    n_fail++; $display("FAIL bp_resume obs=%b/%h exp=1/8030", v_valid, v_data);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(); v_ready = 1'b0; c_ready = 1'b0;
        while (m_t < 150) begin
            @(negedge clk);
            n_tests++;
            if (w_obs !== w_exp) begin
                n_fail++; $display("FAIL ar_model t=%0d obs=%h exp=%h", m_t, w_obs, w_exp);
            end
        end
        n_tests++;
        if ({v_valid, c_valid} !== 2'b11) begin
            n_fail++; $display("FAIL ar_pre obs=%b exp=11", {v_valid, c_valid});
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (w_obs !== 43'd0) begin
            n_fail++; $display("FAIL ar_async obs=%h exp=0", w_obs);
        end
        @(negedge clk) rst_n = 1'b1;
        v_ready = 1'b1; c_ready = 1'b1;
        repeat (205) begin
            @(negedge clk);
            n_tests++;
            if (w_obs !== w_exp) begin
                n_fail++; $display("FAIL ar_restart t=%0d obs=%h exp=%h", m_t, w_obs, w_exp);
            end
            if (m_t == 101) begin
                n_tests++;
                if ({v_data & c_MASK, c_data & c_MASK} !== {16'h8000 & c_MASK, 16'h1000 & c_MASK}) begin
                    n_fail++; $display("FAIL ar_seq obs=%h/%h exp=8000/1000", v_data, c_data);
                end
            end
        end
    endtask

    task automatic test_saturation();
        do_reset(); v_ready = 1'b0; c_ready = 1'b0;
        repeat (200 * P + 5) begin
            @(negedge clk);
            n_tests++;
            if (w_obs !== w_exp) begin
                n_fail++; $display("FAIL sat_model t=%0d obs=%h exp=%h", m_t, w_obs, w_exp);
            end
        end
        n_tests++;
        if (ovf !== 8'hFF) begin
            n_fail++; $display("FAIL sat_final obs=%h exp=ff", ovf);
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (3000) begin
            @(negedge clk);
            n_tests++;
            if (w_obs !== w_exp) begin
                n_fail++; $display("FAIL rand_model t=%0d obs=%h exp=%h", m_t, w_obs, w_exp);
            end
            v_ready = ($urandom_range(0, 99) < 30);
            c_ready = ($urandom_range(0, 99) < 60);
        end
    endtask

    initial begin
        v_ready = 1'b0; c_ready = 1'b0; rst_n = 1'b0;
        test_reset();
        test_first_period();
        test_wrap();
        test_backpressure();
        test_async_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
